// File: rtl/mst_fifo_rd_if.sv
// FT600 245-mode read-side bus plus the captured-word stream that the read
// engine hands to the downstream data checker.
interface mst_fifo_rd_if;
  logic        rxf_n;    // receive FIFO not empty, active low
  logic [15:0] data_in;  // FT600 data bus
  logic [1:0]  be_in;    // FT600 byte enables
  logic        oe_n;     // bus output-enable, active low
  logic        rd_n;     // read strobe, active low
  logic        ch0_vld;  // one-cycle strobe for a captured full word
  logic [15:0] rdata;    // captured word

  // Read engine side
  modport master (
    input  rxf_n, data_in, be_in,
    output oe_n, rd_n, ch0_vld, rdata
  );

  // FT600 chip / stream consumer side
  modport slave (
    output rxf_n, data_in, be_in,
    input  oe_n, rd_n, ch0_vld, rdata
  );
endinterface

// File: rtl/mst_fifo_rd.sv
// FT600 245-mode read engine. Owns the bus through IDLE -> OE -> READ -> END,
// captures one word per clock while the chip reports data, and bounds each
// bus ownership to MAX_BURST captures so the arbiter can hand the bus to the
// write path. Full words leave as a registered one-cycle strobe.
module mst_fifo_rd #(
  parameter int unsigned MAX_BURST = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  mst_fifo_rd_if.master bus,
  output logic          rd_busy,
  output logic          be_err,
  output logic [31:0]   word_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OE   = 2'd1,
    ST_READ = 2'd2,
    ST_END  = 2'd3
  } state_t;

  localparam logic [15:0] BURST_LIM = 16'(MAX_BURST);

  // A captured word is only forwarded when both byte lanes are valid.
  function automatic logic is_full_word(input logic [1:0] be);
    return (be == 2'b11);
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic        oe_n_r;
  logic        rd_n_r;
  logic        rd_busy_r;
  logic        ch0_vld_r;
  logic        be_err_r;
  logic [15:0] rdata_r;
  logic [15:0] burst_cnt_r;
  logic [31:0] word_cnt_r;

  logic        capture_s;
  logic        full_word_s;
  logic        burst_full_s;
  logic        burst_start_s;
  logic        oe_n_nxt_s;
  logic        rd_n_nxt_s;
  logic        busy_nxt_s;

  // rd_n is low exactly while in READ, so every READ edge with data present
  // pulls a word off the chip.
  assign capture_s     = (state_r == ST_READ) && !bus.rxf_n;
  assign full_word_s   = is_full_word(bus.be_in);
  assign burst_full_s  = capture_s && ((burst_cnt_r + 16'd1) == BURST_LIM);
  assign burst_start_s = (state_r == ST_IDLE) && (state_nxt_s == ST_OE);

  // Next-state logic: one turnaround cycle on each side of the READ phase.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_en && !bus.rxf_n) begin
          state_nxt_s = ST_OE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_OE: begin
        state_nxt_s = ST_READ;
      end
      ST_READ: begin
        if (bus.rxf_n || burst_full_s || !rd_en) begin
          state_nxt_s = ST_END;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_END: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Bus strobes decoded from the next state so they are registered yet
  // change on the same edge as the state itself.
  always_comb begin
    oe_n_nxt_s = 1'b1;
    rd_n_nxt_s = 1'b1;
    busy_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        oe_n_nxt_s = 1'b1;
        rd_n_nxt_s = 1'b1;
        busy_nxt_s = 1'b0;
      end
      ST_OE: begin
        oe_n_nxt_s = 1'b0;
        rd_n_nxt_s = 1'b1;
        busy_nxt_s = 1'b1;
      end
      ST_READ: begin
        oe_n_nxt_s = 1'b0;
        rd_n_nxt_s = 1'b0;
        busy_nxt_s = 1'b1;
      end
      ST_END: begin
        oe_n_nxt_s = 1'b1;
        rd_n_nxt_s = 1'b1;
        busy_nxt_s = 1'b1;
      end
      default: begin
        oe_n_nxt_s = 1'b1;
        rd_n_nxt_s = 1'b1;
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // State and bus-control registers; reset releases the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      oe_n_r    <= 1'b1;
      rd_n_r    <= 1'b1;
      rd_busy_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      oe_n_r    <= oe_n_nxt_s;
      rd_n_r    <= rd_n_nxt_s;
      rd_busy_r <= busy_nxt_s;
    end
  end

  // Burst length counter: restarts on every new bus ownership and counts
  // every capture, including partial words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_r <= 16'd0;
    end else if (burst_start_s) begin
      burst_cnt_r <= 16'd0;
    end else if (capture_s) begin
      burst_cnt_r <= burst_cnt_r + 16'd1;
    end else begin
      burst_cnt_r <= burst_cnt_r;
    end
  end

  // Capture path: full words become a one-cycle strobe, partial words only
  // raise the sticky byte-enable error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch0_vld_r  <= 1'b0;
      rdata_r    <= 16'h0000;
      be_err_r   <= 1'b0;
      word_cnt_r <= 32'd0;
    end else begin
      ch0_vld_r <= capture_s && full_word_s;
      if (capture_s && full_word_s) begin
        rdata_r    <= bus.data_in;
        word_cnt_r <= word_cnt_r + 32'd1;
      end else begin
        rdata_r    <= rdata_r;
        word_cnt_r <= word_cnt_r;
      end
      if (capture_s && !full_word_s) begin
        be_err_r <= 1'b1;
      end else begin
        be_err_r <= be_err_r;
      end
    end
  end

  assign bus.oe_n    = oe_n_r;
  assign bus.rd_n    = rd_n_r;
  assign bus.ch0_vld = ch0_vld_r;
  assign bus.rdata   = rdata_r;
  assign rd_busy     = rd_busy_r;
  assign be_err      = be_err_r;
  assign word_cnt    = word_cnt_r;

endmodule

// File: tb/tb_mst_fifo_rd.sv
// Directed bench for mst_fifo_rd: a main instance (MAX_BURST=256) driven by a
// small FT600 FIFO model, plus MAX_BURST=4 and MAX_BURST=1 instances with the
// FIFO held non-empty to check burst framing.
module tb_mst_fifo_rd;

  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic        rd_busy;
  logic        be_err;
  logic [31:0] word_cnt;

  logic        rd_en_s;
  logic        busy4, be_err4, busy1, be_err1;
  logic [31:0] wc4, wc1;

  mst_fifo_rd_if bif();
  mst_fifo_rd_if bif4();
  mst_fifo_rd_if bif1();

  mst_fifo_rd #(.MAX_BURST(256)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .bus(bif),
    .rd_busy(rd_busy), .be_err(be_err), .word_cnt(word_cnt)
  );

  mst_fifo_rd #(.MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en_s), .bus(bif4),
    .rd_busy(busy4), .be_err(be_err4), .word_cnt(wc4)
  );

  mst_fifo_rd #(.MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en_s), .bus(bif1),
    .rd_busy(busy1), .be_err(be_err1), .word_cnt(wc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // FIFO model state for the main instance
  int ft_ptr     = 0;   // value of the word currently on the bus
  int ft_limit   = 0;   // words available are those below this value
  int ft_bad     = -1;  // word presented with be_in = 2'b01
  int stall_at   = -1;  // word at which rxf_n is forced high
  int stall_left = 0;
  bit ft_took    = 1'b0;
  bit chk_exit   = 1'b0;
  bit tb_rd_en   = 1'b0;
  int exp_rdata  = 0;
  int n_vld      = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock of the FIFO model: account for the word taken at the edge just
  // passed, score any strobe, then drive the bus for the next edge.
  task automatic step();
    @(negedge clk);
    if (ft_took) ft_ptr++;
    if (chk_exit) begin
      check("stall_exit_rd_n", 32'(bif.rd_n), 32'd1);
      check("stall_exit_vld", 32'(bif.ch0_vld), 32'd0);
      chk_exit = 1'b0;
    end
    if (bif.ch0_vld) begin
      if (exp_rdata == ft_bad) exp_rdata++;
      check("rdata_seq", 32'(bif.rdata), 32'(exp_rdata));
      exp_rdata++;
      n_vld++;
    end
    if (stall_left > 0 && ft_ptr == stall_at) begin
      if (stall_left == 3) chk_exit = 1'b1;
      stall_left--;
      bif.rxf_n = 1'b1;
    end else begin
      bif.rxf_n = (ft_ptr >= ft_limit);
    end
    bif.data_in = ft_ptr[15:0];
    bif.be_in   = (ft_ptr == ft_bad) ? 2'b01 : 2'b11;
    rd_en       = tb_rd_en;
    ft_took     = !bif.rd_n && !bif.rxf_n;
  endtask

  // Step until the target count of strobes is seen and the engine is idle.
  task automatic run_until(input int target, input int budget);
    int b;
    b = 0;
    do begin
      step();
      b++;
    end while ((n_vld < target || rd_busy) && b < budget);
    check("run_until_done", 32'(n_vld < target || rd_busy), 32'd0);
  endtask

  initial begin
    int b;
    logic [15:0] d4, d1;
    bit took4, took1;
    int e4, e1;

    rst_n = 1'b0;
    rd_en = 1'b0;
    rd_en_s = 1'b0;
    bif.rxf_n = 1'b1;  bif.data_in = 16'h0000;  bif.be_in = 2'b11;
    bif4.rxf_n = 1'b0; bif4.data_in = 16'h0000; bif4.be_in = 2'b11;
    bif1.rxf_n = 1'b0; bif1.data_in = 16'h0000; bif1.be_in = 2'b11;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_oe_n", 32'(bif.oe_n), 32'd1);
    check("rst_rd_n", 32'(bif.rd_n), 32'd1);
    check("rst_busy", 32'(rd_busy), 32'd0);
    check("rst_vld", 32'(bif.ch0_vld), 32'd0);
    check("rst_rdata", 32'(bif.rdata), 32'd0);
    check("rst_be_err", 32'(be_err), 32'd0);
    check("rst_word_cnt", word_cnt, 32'd0);
    rst_n = 1'b1;

    // Ten-word burst, FIFO empties afterwards
    ft_limit = 10;
    tb_rd_en = 1'b1;
    step();                       // drives the start edge E0
    step();                       // after E0
    check("e0_oe_n", 32'(bif.oe_n), 32'd0);
    check("e0_rd_n", 32'(bif.rd_n), 32'd1);
    check("e0_busy", 32'(rd_busy), 32'd1);
    step();                       // after E1
    check("e1_oe_n", 32'(bif.oe_n), 32'd0);
    check("e1_rd_n", 32'(bif.rd_n), 32'd0);
    check("e1_vld", 32'(bif.ch0_vld), 32'd0);
    step();                       // after E2, first capture
    check("e2_vld", 32'(bif.ch0_vld), 32'd1);
    repeat (9) step();
    check("w9_vld", 32'(bif.ch0_vld), 32'd1);
    check("w9_rdata", 32'(bif.rdata), 32'h0009);
    step();                       // empty sample -> END
    check("end_oe_n", 32'(bif.oe_n), 32'd1);
    check("end_rd_n", 32'(bif.rd_n), 32'd1);
    check("end_vld", 32'(bif.ch0_vld), 32'd0);
    check("end_busy", 32'(rd_busy), 32'd1);
    check("t1_word_cnt", word_cnt, 32'd10);
    step();
    check("idle_busy", 32'(rd_busy), 32'd0);
    check("idle_oe_n", 32'(bif.oe_n), 32'd1);
    check("t1_n_vld", 32'(n_vld), 32'd10);

    // Words 10..14, word 12 has only the low byte enabled
    ft_bad = 12;
    ft_limit = 15;
    run_until(14, 60);
    check("be_word_cnt", word_cnt, 32'd14);
    check("be_err_set", 32'(be_err), 32'd1);
    check("be_last_rdata", 32'(bif.rdata), 32'h000e);

    // Words 15..29 with rxf_n high for three cycles before word 20
    stall_at = 20;
    stall_left = 3;
    ft_limit = 30;
    run_until(29, 80);
    check("stall_word_cnt", word_cnt, 32'd29);
    check("stall_last_rdata", 32'(bif.rdata), 32'h001d);
    check("stall_done", 32'(stall_left), 32'd0);

    // Grant dropped mid-READ with data available
    ft_limit = 40;
    b = 0;
    while (n_vld < 32 && b < 100) begin
      step();
      b++;
    end
    check("drop_pre_rd_n", 32'(bif.rd_n), 32'd0);
    tb_rd_en = 1'b0;
    rd_en = 1'b0;
    step();
    check("drop_word", 32'(n_vld), 32'd33);
    check("drop_rd_n", 32'(bif.rd_n), 32'd1);
    check("drop_oe_n", 32'(bif.oe_n), 32'd1);
    repeat (4) step();
    check("drop_no_start_busy", 32'(rd_busy), 32'd0);
    check("drop_no_start_oe_n", 32'(bif.oe_n), 32'd1);
    check("drop_no_extra", 32'(n_vld), 32'd33);
    tb_rd_en = 1'b1;
    run_until(39, 60);
    check("drop_word_cnt", word_cnt, 32'd39);
    check("drop_last_rdata", 32'(bif.rdata), 32'h0027);
    check("be_err_sticky", 32'(be_err), 32'd1);

    // Asynchronous reset in the middle of READ
    ft_limit = 60;
    b = 0;
    while (n_vld < 42 && b < 100) begin
      step();
      b++;
    end
    check("rst_pre_rd_n", 32'(bif.rd_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_oe_n", 32'(bif.oe_n), 32'd1);
    check("arst_rd_n", 32'(bif.rd_n), 32'd1);
    check("arst_vld", 32'(bif.ch0_vld), 32'd0);
    check("arst_word_cnt", word_cnt, 32'd0);
    check("arst_busy", 32'(rd_busy), 32'd0);
    check("arst_be_err", 32'(be_err), 32'd0);
    ft_took = 1'b0;
    tb_rd_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vld = 0;
    exp_rdata = ft_ptr;
    repeat (3) step();            // data present, no grant
    check("post_rst_no_grant", 32'(rd_busy), 32'd0);
    tb_rd_en = 1'b1;
    ft_limit = ft_ptr;
    repeat (3) step();            // grant, no data
    check("post_rst_no_data", 32'(rd_busy), 32'd0);
    check("post_rst_oe_n", 32'(bif.oe_n), 32'd1);
    ft_limit = ft_ptr + 3;
    run_until(3, 40);
    check("post_rst_word_cnt", word_cnt, 32'd3);
    check("post_rst_rdata", 32'(bif.rdata), 32'h002d);

    // Burst framing with the FIFO never empty: MAX_BURST=4 and MAX_BURST=1
    d4 = 16'h0000; d1 = 16'h0000;
    e4 = 0; e1 = 0;
    @(negedge clk);
    rd_en_s = 1'b1;
    took4 = !bif4.rd_n;
    took1 = !bif1.rd_n;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      check("mb4_vld", 32'(bif4.ch0_vld), 32'((i >= 2) && (((i - 2) % 7) < 4)));
      check("mb1_vld", 32'(bif1.ch0_vld), 32'((i >= 2) && (((i - 2) % 4) == 0)));
      if (bif4.ch0_vld) begin
        check("mb4_rdata", 32'(bif4.rdata), 32'(e4));
        e4++;
      end
      if (bif1.ch0_vld) begin
        check("mb1_rdata", 32'(bif1.rdata), 32'(e1));
        e1++;
      end
      if (took4) d4 = d4 + 16'd1;
      if (took1) d1 = d1 + 16'd1;
      bif4.data_in = d4;
      bif1.data_in = d1;
      took4 = !bif4.rd_n;
      took1 = !bif1.rd_n;
    end
    check("mb4_word_cnt", wc4, 32'd16);
    check("mb1_word_cnt", wc1, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
